// File: rtl/div_pkg.sv
// Shared definitions for the iterative 32-bit divider: state encodings,
// handshake constants, bus widths and a two's-complement helper.
package div_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   localparam int RegBus       = 32;
   localparam int DoubleRegBus = 64;

   function automatic logic [RegBus-1:0] neg32(input logic [RegBus-1:0] v);
      return ~v + 32'd1;
   endfunction

endpackage

// File: rtl/div.sv
// Iterative restoring divider, one quotient bit per cycle, fixed latency.
// Signed operation is compiled in only when DIV_SIGNED_EN is defined.
module div
   import div_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    signed_div_i,
   input  logic [RegBus-1:0]       opdata1_i,
   input  logic [RegBus-1:0]       opdata2_i,
   input  logic                    start_i,
   input  logic                    annul_i,
   output logic [DoubleRegBus-1:0] result_o,
   output logic                    ready_o
);

   div_state_e              state_r, state_s;
   logic [5:0]              cnt_r, cnt_s;
   logic [64:0]             work_r, work_s;
   logic [RegBus-1:0]       divisor_r, divisor_s;
   logic [DoubleRegBus-1:0] result_r, result_s;
   logic                    ready_r, ready_s;
   logic [32:0]             trial_s;
   logic [RegBus-1:0]       op1_mag_s, op2_mag_s, quo_s, rem_s;

`ifdef DIV_SIGNED_EN
   logic neg_quo_r, neg_quo_s, neg_rem_r, neg_rem_s;

   assign op1_mag_s = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
   assign op2_mag_s = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
   assign quo_s     = neg_quo_r ? neg32(work_r[31:0])  : work_r[31:0];
   assign rem_s     = neg_rem_r ? neg32(work_r[64:33]) : work_r[64:33];
`else
   logic unused_signed_s;

   assign unused_signed_s = signed_div_i;
   assign op1_mag_s       = opdata1_i;
   assign op2_mag_s       = opdata2_i;
   assign quo_s           = work_r[31:0];
   assign rem_s           = work_r[64:33];
`endif

   // Remainder window w[64:33] shifted left one bit, pulling in the next dividend bit.
   assign trial_s = {1'b0, work_r[63:32]} - {1'b0, divisor_r};

   // Next-state and datapath update for the divider FSM.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      work_s    = work_r;
      divisor_s = divisor_r;
      result_s  = result_r;
      ready_s   = ready_r;
`ifdef DIV_SIGNED_EN
      neg_quo_s = neg_quo_r;
      neg_rem_s = neg_rem_r;
`endif
      case (state_r)
         DivFree: begin
            if (start_i == DivStart && !annul_i) begin
               if (opdata2_i == 32'd0) begin
                  state_s = DivByZero;
               end else begin
                  state_s   = DivOn;
                  cnt_s     = 6'd0;
                  work_s    = {32'd0, op1_mag_s, 1'b0};
                  divisor_s = op2_mag_s;
`ifdef DIV_SIGNED_EN
                  neg_quo_s = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                  neg_rem_s = signed_div_i && opdata1_i[31];
`endif
               end
            end else begin
               ready_s  = DivResultNotReady;
               result_s = 64'd0;
            end
         end
         DivByZero: begin
            work_s   = 65'd0;
            state_s  = DivEnd;
            result_s = 64'd0;
            ready_s  = DivResultReady;
         end
         DivOn: begin
            if (annul_i) begin
               state_s  = DivFree;
               cnt_s    = 6'd0;
               ready_s  = DivResultNotReady;
               result_s = 64'd0;
            end else if (cnt_r < 6'd32) begin
               if (trial_s[32]) begin
                  work_s = {work_r[63:0], 1'b0};
               end else begin
                  work_s = {trial_s[31:0], work_r[31:0], 1'b1};
               end
               cnt_s = cnt_r + 6'd1;
            end else begin
               state_s  = DivEnd;
               cnt_s    = 6'd0;
               result_s = {rem_s, quo_s};
               ready_s  = DivResultReady;
            end
         end
         DivEnd: begin
            if (start_i == DivStop) begin
               state_s  = DivFree;
               ready_s  = DivResultNotReady;
               result_s = 64'd0;
            end else begin
               ready_s  = DivResultReady;
            end
         end
         default: begin
            state_s  = DivFree;
            cnt_s    = 6'd0;
            ready_s  = DivResultNotReady;
            result_s = 64'd0;
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= DivFree;
         cnt_r     <= 6'd0;
         work_r    <= 65'd0;
         divisor_r <= 32'd0;
         result_r  <= 64'd0;
         ready_r   <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
         neg_quo_r <= 1'b0;
         neg_rem_r <= 1'b0;
`endif
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         work_r    <= work_s;
         divisor_r <= divisor_s;
         result_r  <= result_s;
         ready_r   <= ready_s;
`ifdef DIV_SIGNED_EN
         neg_quo_r <= neg_quo_s;
         neg_rem_r <= neg_rem_s;
`endif
      end
   end

   assign result_o = result_r;
   assign ready_o  = ready_r;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed vector table, random operands against
// an arithmetic reference, plus annul and asynchronous reset sequences.
module tb_div;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        signed_div = 1'b0;
   logic [31:0] opdata1 = 32'd0;
   logic [31:0] opdata2 = 32'd0;
   logic        start = 1'b0;
   logic        annul = 1'b0;
   logic [63:0] result;
   logic        ready;

   int pass_cnt  = 0;
   int total_cnt = 0;

`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (opdata1),
      .opdata2_i    (opdata2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference: plain integer division, truncating toward zero.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn && SIGNED_EN) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp_res, input int exp_lat);
      int edges = 0;
      bit seen = 1'b0;
      logic [63:0] held;
      @(negedge clk);
      opdata1 = a; opdata2 = b; signed_div = sgn; start = 1'b1;
      while (edges < 60 && !seen) begin
         @(posedge clk); #1;
         edges++;
         if (edges == 1) begin
            opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
         end
         seen = ready;
      end
      check({name, " latency"}, 64'(edges), 64'(exp_lat));
      check({name, " result"}, result, exp_res);
      held = result;
      @(posedge clk); #1;
      check({name, " hold ready"}, 64'(ready), 64'd1);
      check({name, " hold result"}, result, held);
      start = 1'b0;
      @(posedge clk); #1;
      check({name, " release ready"}, 64'(ready), 64'd0);
      check({name, " release result"}, result, 64'd0);
   endtask

   task automatic watch_quiet(input string name, input int cycles);
      int highs = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (ready) highs++;
      end
      check(name, 64'(highs), 64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      int          edges;

      #1;
      check("reset ready", 64'(ready), 64'd0);
      check("reset result", result, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      vecs.push_back('{"u100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34});
      vecs.push_back('{"div0", 32'd100, 32'd0, 1'b0, 64'd0, 2});
      vecs.push_back('{"0/0", 32'd0, 32'd0, 1'b1, 64'd0, 2});
      vecs.push_back('{"ffff/10", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 34});
      vecs.push_back('{"x/1", 32'h1234_5678, 32'd1, 1'b0, {32'd0, 32'h1234_5678}, 34});
      vecs.push_back('{"5/max", 32'd5, 32'hFFFF_FFFF, 1'b0, {32'd5, 32'd0}, 34});
`ifdef DIV_SIGNED_EN
      vecs.push_back('{"s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34});
      vecs.push_back('{"smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 34});
      vecs.push_back('{"s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 34});
`else
      vecs.push_back('{"s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'd1, 32'h7FFF_FFFC}, 34});
      vecs.push_back('{"smin/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'd0}, 34});
      vecs.push_back('{"s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd7, 32'd0}, 34});
`endif
      foreach (vecs[i]) run_div(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, vecs[i].lat);

      for (int i = 0; i < 24; i++) begin
         ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'($urandom_range(0, 20));
            1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            default: rb = $urandom;
         endcase
         rs = 1'($urandom);
         run_div("rand", ra, rb, rs, ref_div(ra, rb, rs), (rb == 32'd0) ? 2 : 34);
      end

      // annul held with start: no acceptance until annul drops
      @(negedge clk);
      opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1; annul = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("annul blocks accept", 64'(ready), 64'd0);
      @(negedge clk);
      annul = 1'b0;
      edges = 0;
      while (edges < 60 && !ready) begin
         @(posedge clk); #1;
         edges++;
      end
      check("accept after annul latency", 64'(edges), 64'd34);
      check("accept after annul result", result, {32'd2, 32'd14});
      @(negedge clk);
      start = 1'b0;

      // annul mid-division
      @(negedge clk);
      opdata1 = 32'd50; opdata2 = 32'd7; start = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      annul = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      check("annul ready", 64'(ready), 64'd0);
      annul = 1'b0;
      watch_quiet("annul no result", 40);
      run_div("after annul 9/3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 34);

      // asynchronous reset at cycle 20 of a division
      @(negedge clk);
      opdata1 = 32'h1234_5678; opdata2 = 32'd3; start = 1'b1;
      repeat (20) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst ready", 64'(ready), 64'd0);
      check("midrst result", result, 64'd0);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      watch_quiet("midrst no partial", 40);
      run_div("post rst ffff/10", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 34);

      // asynchronous reset while a result is held
      @(negedge clk);
      opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
      edges = 0;
      while (edges < 60 && !ready) begin
         @(posedge clk); #1;
         edges++;
      end
      check("held before rst", result, {32'd2, 32'd14});
      #2 rst = 1'b0;
      #1;
      check("endrst ready", 64'(ready), 64'd0);
      check("endrst result", result, 64'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_div("post endrst 9/3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 34);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
